// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: PC/control from the pipeline, SRAM read data in,
// SRAM chip select, next-PC increment and the (pc, inst, valid) triple
// toward decode. The master modport is the fetch stage itself.
interface if_fetch_stage_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
);
    logic [PC_WIDTH-1:0]   pc_i;
    logic                  stall_i;
    logic                  flush_i;
    logic [INST_WIDTH-1:0] imem_rdata_i;
    logic                  imem_cs_o;
    logic [PC_WIDTH-1:0]   pc_plus4_o;
    logic [PC_WIDTH-1:0]   if_pc_o;
    logic [INST_WIDTH-1:0] if_inst_o;
    logic                  if_valid_o;

    modport master (
        input  pc_i,
        input  stall_i,
        input  flush_i,
        input  imem_rdata_i,
        output imem_cs_o,
        output pc_plus4_o,
        output if_pc_o,
        output if_inst_o,
        output if_valid_o
    );

    modport slave (
        output pc_i,
        output stall_i,
        output flush_i,
        output imem_rdata_i,
        input  imem_cs_o,
        input  pc_plus4_o,
        input  if_pc_o,
        input  if_inst_o,
        input  if_valid_o
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Pairs the SRAM word returned one cycle after
// the address with the PC that fetched it, freezes that pair across
// stalls with a one-entry hold buffer, and squashes wrong-path fetches
// on flush. The SRAM read data is only trusted in the cycle right after
// a chip-select, so the first stalled cycle snapshots it into the hold
// buffer before the select drops.
module if_fetch_stage #(
    parameter int                    PC_WIDTH   = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic clk_i,
    input  logic rst_ni,
    if_fetch_stage_if.master bus
);

    logic                  req_valid_q;
    logic [PC_WIDTH-1:0]   req_pc_q;
    logic                  hold_valid_q;
    logic [INST_WIDTH-1:0] hold_inst_q;
    logic [INST_WIDTH-1:0] inst_sel;

    // Decode-side instruction: held word wins, then live SRAM data, else bubble.
    always_comb begin
        inst_sel = NOP_INST;
        if (hold_valid_q) begin
            inst_sel = hold_inst_q;
        end else if (req_valid_q) begin
            inst_sel = bus.imem_rdata_i;
        end
    end

    assign bus.imem_cs_o  = ~bus.stall_i;
    assign bus.pc_plus4_o = bus.pc_i + PC_WIDTH'(4);
    assign bus.if_pc_o    = req_pc_q;
    assign bus.if_valid_o = req_valid_q;
    assign bus.if_inst_o  = inst_sel;

    // Request tracking and hold buffer; flush beats stall, stall beats advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_valid_q  <= 1'b0;
            req_pc_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_inst_q  <= NOP_INST;
        end else if (bus.flush_i) begin
            req_valid_q  <= 1'b0;
            req_pc_q     <= bus.pc_i;
            hold_valid_q <= 1'b0;
        end else if (bus.stall_i) begin
            if (!hold_valid_q) begin
                hold_inst_q  <= inst_sel;
                hold_valid_q <= 1'b1;
            end
        end else begin
            req_valid_q  <= 1'b1;
            req_pc_q     <= bus.pc_i;
            hold_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: the stimulus process drives one
// directed vector per cycle and queues the hand-computed outputs for
// that cycle; a monitor pops and compares at every falling edge.
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_fetch_stage_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();

    if_fetch_stage #(.PC_WIDTH(32), .INST_WIDTH(32), .NOP_INST(NOP)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // SRAM model: one-cycle read latency, undefined data when not selected.
    logic [31:0] mem_addr = '0;
    logic        mem_ok   = 1'b0;
    always @(posedge clk) begin
        if (bus.imem_cs_o === 1'b1) begin
            mem_addr <= bus.pc_i;
            mem_ok   <= 1'b1;
        end else begin
            mem_ok   <= 1'b0;
        end
    end
    assign bus.imem_rdata_i = mem_ok ? (32'hAAAA_0000 + mem_addr) : 'x;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        cs;
        logic [31:0] p4;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("valid", e.cyc, {31'd0, bus.if_valid_o}, {31'd0, e.v});
            chk("pc",    e.cyc, bus.if_pc_o, e.pc);
            chk("inst",  e.cyc, bus.if_inst_o, e.inst);
            chk("cs",    e.cyc, {31'd0, bus.imem_cs_o}, {31'd0, e.cs});
            chk("plus4", e.cyc, bus.pc_plus4_o, e.p4);
        end
    end

    task automatic step(input logic r, input logic [31:0] pc, input logic st, input logic fl,
                        input logic ev, input logic [31:0] epc, input logic [31:0] einst);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n       = r;
        bus.pc_i    = pc;
        bus.stall_i = st;
        bus.flush_i = fl;
        e.v    = ev;
        e.pc   = epc;
        e.inst = einst;
        e.cs   = ~st;
        e.p4   = pc + 32'd4;
        e.cyc  = cyc;
        q.push_back(e);
        cyc++;
    endtask

    initial begin
        bus.pc_i    = '0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        //    rst  pc             stall flush  valid pc            inst
        // reset held for three cycles
        step(0, 32'h0000_0000, 0, 0,   0, 32'h0000_0000, NOP);
        step(0, 32'h0000_0000, 0, 0,   0, 32'h0000_0000, NOP);
        step(0, 32'h0000_0000, 0, 0,   0, 32'h0000_0000, NOP);
        // release and stream
        step(1, 32'h0000_0000, 0, 0,   0, 32'h0000_0000, NOP);
        step(1, 32'h0000_0004, 0, 0,   1, 32'h0000_0000, 32'hAAAA_0000);
        step(1, 32'h0000_0008, 0, 0,   1, 32'h0000_0004, 32'hAAAA_0004);
        step(1, 32'h0000_000C, 0, 0,   1, 32'h0000_0008, 32'hAAAA_0008);
        step(1, 32'h0000_0010, 0, 0,   1, 32'h0000_000C, 32'hAAAA_000C);
        // three-cycle stall with 0x10 on the outputs, then release
        step(1, 32'h0000_0014, 1, 0,   1, 32'h0000_0010, 32'hAAAA_0010);
        step(1, 32'h0000_0014, 1, 0,   1, 32'h0000_0010, 32'hAAAA_0010);
        step(1, 32'h0000_0014, 1, 0,   1, 32'h0000_0010, 32'hAAAA_0010);
        step(1, 32'h0000_0014, 0, 0,   1, 32'h0000_0010, 32'hAAAA_0010);
        step(1, 32'h0000_0018, 0, 0,   1, 32'h0000_0014, 32'hAAAA_0014);
        step(1, 32'h0000_001C, 0, 0,   1, 32'h0000_0018, 32'hAAAA_0018);
        // flush while 0x20 is fetched, redirect to 0x100
        step(1, 32'h0000_0020, 0, 1,   1, 32'h0000_001C, 32'hAAAA_001C);
        step(1, 32'h0000_0100, 0, 0,   0, 32'h0000_0020, NOP);
        step(1, 32'h0000_0104, 0, 0,   1, 32'h0000_0100, 32'hAAAA_0100);
        // stall, then flush on a stalled cycle
        step(1, 32'h0000_0108, 1, 0,   1, 32'h0000_0104, 32'hAAAA_0104);
        step(1, 32'h0000_0108, 1, 1,   1, 32'h0000_0104, 32'hAAAA_0104);
        step(1, 32'h0000_0200, 0, 0,   0, 32'h0000_0108, NOP);
        // PC wrap on the incrementer
        step(1, 32'hFFFF_FFFC, 0, 0,   1, 32'h0000_0200, 32'hAAAA_0200);
        step(1, 32'h0000_0000, 0, 0,   1, 32'hFFFF_FFFC, 32'hAAA9_FFFC);
        // stall to load the hold buffer, then async reset between edges
        step(1, 32'h0000_0004, 1, 0,   1, 32'h0000_0000, 32'hAAAA_0000);
        step(0, 32'h0000_0004, 1, 0,   0, 32'h0000_0000, NOP);
        step(0, 32'h0000_0000, 0, 0,   0, 32'h0000_0000, NOP);
        // restart
        step(1, 32'h0000_0000, 0, 0,   0, 32'h0000_0000, NOP);
        step(1, 32'h0000_0004, 0, 0,   1, 32'h0000_0000, 32'hAAAA_0000);
        step(1, 32'h0000_0008, 0, 0,   1, 32'h0000_0004, 32'hAAAA_0004);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
